// File: rtl/elm_pkg.sv
// rtl/elm_pkg.sv - shared ELM pipeline types and default dimensions
package elm_pkg;

  localparam int ELM_CLASSES = 10;
  localparam int ELM_SCORE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - combinational signed/unsigned score compare
module argmax_cmp #(
  parameter int DATA_W     = 16,
  parameter int SIGNED_CMP = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              lt_threshold
);

  always_comb begin
    if (SIGNED_CMP != 0) begin
      gt           = $signed(a) > $signed(b);
      lt_threshold = $signed(a) < $signed(b);
    end else begin
      gt           = a > b;
      lt_threshold = a < b;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - streaming argmax over one score per class with threshold reject
module argmax_classifier
  import elm_pkg::*;
#(
  parameter  int NUM_CLASSES = ELM_CLASSES,
  parameter  int DATA_W      = ELM_SCORE_W,
  parameter  int SIGNED_CMP  = 1,
  parameter  int REJECT_EN   = 1,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              score_valid,
  input  logic [DATA_W-1:0] score_data,
  output logic              score_ready,
  input  logic [DATA_W-1:0] threshold,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_score,
  output logic              rejected,
  output logic              done,
  output logic              busy
);

  state_t state, state_nx;

  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] thr_q;
  logic              rej_q;

  logic              accept, first, last;
  logic              gt, lt_unused, gt_unused, below_thr;
  logic [DATA_W-1:0] new_max;

  assign accept  = score_valid && (state == COMP);
  assign first   = (cnt == '0);
  assign last    = (cnt == IDX_W'(NUM_CLASSES - 1));
  assign new_max = gt ? score_data : max_q;

  argmax_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_score_cmp (
    .a            (score_data),
    .b            (max_q),
    .gt           (gt),
    .lt_threshold (lt_unused)
  );

  // The threshold check sees the max including the final beat's compare.
  argmax_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_thr_cmp (
    .a            (new_max),
    .b            (thr_q),
    .gt           (gt_unused),
    .lt_threshold (below_thr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    score_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (start) state_nx = COMP;
      COMP: begin
        busy        = 1'b1;
        score_ready = 1'b1;
        if (accept && last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = COMP;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      idx_q <= '0;
      max_q <= '0;
      thr_q <= '0;
      rej_q <= 1'b0;
    end else begin
      if (start && (state == IDLE || state == DONE)) begin
        cnt <= '0;
      end else if (accept && !last) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        if (first) begin
          max_q <= score_data;
          idx_q <= '0;
          thr_q <= threshold;
          rej_q <= 1'b0;
        end else begin
          // Strictly greater keeps the lower index on ties.
          if (gt) begin
            max_q <= score_data;
            idx_q <= cnt;
          end
          if (last) rej_q <= (REJECT_EN != 0) && below_thr;
        end
      end
    end
  end

  assign class_idx = idx_q;
  assign max_score = max_q;
  assign rejected  = rej_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - directed vector bench for argmax_classifier
module tb_argmax_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        score_valid = 1'b0;
  logic [15:0] score_data = '0;
  logic [15:0] threshold = '0;

  logic        d_ready, d_rej, d_done, d_busy;
  logic [3:0]  d_idx;
  logic [15:0] d_max;
  logic        u_ready, u_rej, u_done, u_busy;
  logic [3:0]  u_idx;
  logic [15:0] u_max;

  logic        s_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic [7:0]  s_thr = '0;
  logic        s_ready, s_rej, s_done, s_busy;
  logic [0:0]  s_idx;
  logic [7:0]  s_max;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  argmax_classifier u_dut (
    .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
    .score_data(score_data), .score_ready(d_ready), .threshold(threshold),
    .class_idx(d_idx), .max_score(d_max), .rejected(d_rej), .done(d_done), .busy(d_busy)
  );

  argmax_classifier #(.SIGNED_CMP(0)) u_uns (
    .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
    .score_data(score_data), .score_ready(u_ready), .threshold(threshold),
    .class_idx(u_idx), .max_score(u_max), .rejected(u_rej), .done(u_done), .busy(u_busy)
  );

  argmax_classifier #(.NUM_CLASSES(2), .DATA_W(8), .REJECT_EN(0)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .score_valid(s_valid),
    .score_data(s_data), .score_ready(s_ready), .threshold(s_thr),
    .class_idx(s_idx), .max_score(s_max), .rejected(s_rej), .done(s_done), .busy(s_busy)
  );

  typedef struct packed {
    logic [15:0] thr;
    logic [3:0]  idx;
    logic [15:0] mx;
    logic        rej;
    logic [3:0]  uidx;
    logic [15:0] umx;
    logic        urej;
  } vec_t;

  localparam int NV = 7;
  int   tbl_sc [NV][10];
  vec_t tbl [NV];
  int   sc [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Assumes the caller is away from the rising edge; drives sc[] with 'gap' idle cycles between beats.
  task automatic feed(input logic [15:0] thr, input int gap, input string tag);
    bit busy_ok;
    bit early_done;
    busy_ok = 1'b1;
    early_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s_started", tag), {d_done, d_busy, d_ready}, 3'b011);
    for (int i = 0; i < 10; i++) begin
      score_valid = 1'b1;
      score_data  = 16'(sc[i]);
      threshold   = (i == 0) ? thr : 16'h1234;
      @(posedge clk);
      @(negedge clk);
      if (i < 9) begin
        busy_ok    &= d_busy;
        early_done |= d_done;
        for (int g = 0; g < gap; g++) begin
          score_valid = 1'b0;
          score_data  = 16'h7FFF;
          @(posedge clk);
          @(negedge clk);
          busy_ok    &= d_busy;
          early_done |= d_done;
        end
      end
    end
    score_valid = 1'b0;
    chk($sformatf("%s_busy_held", tag), busy_ok, 1'b1);
    chk($sformatf("%s_no_early_done", tag), early_done, 1'b0);
    chk($sformatf("%s_done", tag), {d_done, d_busy, d_ready}, 3'b100);
  endtask

  initial begin
    tbl_sc[0] = '{3, 7, 2, 9, 1, 0, 4, 9, 5, 6};
    tbl[0]    = '{thr:16'd5, idx:4'd3, mx:16'd9, rej:1'b0, uidx:4'd3, umx:16'd9, urej:1'b0};
    tbl_sc[1] = '{-5, -2, -8, -3, -4, -6, -7, -10, -2, -9};
    tbl[1]    = '{thr:16'd0, idx:4'd1, mx:16'hFFFE, rej:1'b1, uidx:4'd1, umx:16'hFFFE, urej:1'b0};
    tbl_sc[2] = '{-1, 5, 100, -32768, 0, 7, 100, 2, 3, 4};
    tbl[2]    = '{thr:16'd50, idx:4'd2, mx:16'd100, rej:1'b0, uidx:4'd0, umx:16'hFFFF, urej:1'b0};
    tbl_sc[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[3]    = '{thr:16'd1, idx:4'd9, mx:16'd1, rej:1'b0, uidx:4'd9, umx:16'd1, urej:1'b0};
    tbl_sc[4] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    tbl[4]    = '{thr:16'd5, idx:4'd0, mx:16'd4, rej:1'b1, uidx:4'd0, umx:16'd4, urej:1'b1};
    tbl_sc[5] = '{-20, -30, -10, -40, -50, -60, -70, -80, -90, -15};
    tbl[5]    = '{thr:16'hFFF6, idx:4'd2, mx:16'hFFF6, rej:1'b0, uidx:4'd2, umx:16'hFFF6, urej:1'b0};
    tbl_sc[6] = tbl_sc[5];
    tbl[6]    = '{thr:16'hFFF7, idx:4'd2, mx:16'hFFF6, rej:1'b1, uidx:4'd2, umx:16'hFFF6, urej:1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {d_ready, d_idx, d_max, d_rej, d_done, d_busy}, 24'h0);
    chk("reset_small", {s_ready, s_idx, s_max, s_rej, s_done, s_busy}, 13'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {d_ready, d_done, d_busy}, 3'b000);

    for (int v = 0; v < NV; v++) begin
      sc = tbl_sc[v];
      feed(tbl[v].thr, 0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_signed", v), {d_idx, d_max, d_rej}, {tbl[v].idx, tbl[v].mx, tbl[v].rej});
      chk($sformatf("vec%0d_unsigned", v), {u_idx, u_max, u_rej}, {tbl[v].uidx, tbl[v].umx, tbl[v].urej});
    end

    // Bursty stream must match the back-to-back result.
    sc = tbl_sc[0];
    feed(16'd5, 2, "bursty");
    chk("bursty_result", {d_idx, d_max, d_rej}, {4'd3, 16'd9, 1'b0});

    // start inside COMP is ignored.
    sc = tbl_sc[3];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    threshold = 16'd1;
    for (int i = 0; i < 10; i++) begin
      score_valid = 1'b1;
      score_data  = 16'(sc[i]);
      start       = (i == 5);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    score_valid = 1'b0;
    chk("midstart_done", d_done, 1'b1);
    chk("midstart_result", {d_idx, d_max, d_rej}, {4'd9, 16'd1, 1'b0});

    // Asynchronous reset after five accepted beats.
    sc = tbl_sc[0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    threshold = 16'd5;
    for (int i = 0; i < 5; i++) begin
      score_valid = 1'b1;
      score_data  = 16'(sc[i]);
      @(posedge clk);
      @(negedge clk);
    end
    chk("partial_max", {d_busy, d_idx, d_max}, {1'b1, 4'd3, 16'd9});
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {d_ready, d_idx, d_max, d_rej, d_done, d_busy}, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", i), {d_ready, d_done, d_busy}, 3'b000);
    end
    score_valid = 1'b0;
    feed(16'd5, 0, "after_reset");
    chk("after_reset_result", {d_idx, d_max, d_rej}, {4'd3, 16'd9, 1'b0});

    // Two-class instance, minimum latency, reject disabled.
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h80;
    s_thr   = 8'h7F;
    @(posedge clk);
    @(negedge clk);
    chk("small_beat0", {s_done, s_busy}, 2'b01);
    s_data = 8'h7F;
    s_thr  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("small_result1", {s_done, s_idx, s_max, s_rej}, {1'b1, 1'b1, 8'h7F, 1'b0});
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    chk("small_restart", {s_done, s_busy}, 2'b01);
    s_valid = 1'b1;
    s_data  = 8'h80;
    s_thr   = 8'h00;
    @(posedge clk);
    @(negedge clk);
    s_data = 8'h81;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("small_result2", {s_done, s_idx, s_max, s_rej}, {1'b1, 1'b1, 8'h81, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Parametrised argmax stage that closes the ELM inference pipeline. It consumes the output-layer scores one class per beat from the upstream layer engine and tracks the running maximum and its index.
- On completion it presents the winning class, its score and an optional low-confidence reject flag.
- Generalises the fixed 10-class compare controller with:
  - configurable class count and score width
  - signed or unsigned compare
  - a valid/ready input handshake
  - a deterministic tie rule
  - a threshold reject mode
  - an integrated datapath

Parameters:
NUM_CLASSES, 10, number of scores per inference (2..256)
DATA_W, 16, score width in bits
SIGNED_CMP, 1, 1 = two's-complement compare, 0 = unsigned compare
REJECT_EN, 1, 1 = enable threshold reject logic; 0 = rejected tied to 0
IDX_W, $clog2(NUM_CLASSES), class index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; arms a new inference (accepted in IDLE or DONE)
score_valid  input  1  score_data valid this cycle
score_data  input  DATA_W  score of the current class; classes arrive in order 0..NUM_CLASSES-1
score_ready  output  1  block accepts a score this cycle
threshold  input  DATA_W  reject threshold; sampled once on the first accepted beat
class_idx  output  IDX_W  index of the maximum score
max_score  output  DATA_W  maximum score value
rejected  output  1  REJECT_EN and max_score < threshold (compared in SIGNED_CMP mode)
done  output  1  high while results are valid (DONE state)
busy  output  1  high in COMP

Behaviour:
- Reset: asynchronous, active-low. While asserted, state=IDLE and all outputs are 0: score_ready, class_idx, max_score, rejected, done, busy. Internal counter and threshold register are also cleared.
- State IDLE:
  - score_ready=0.
  - start -> COMP, with counter cleared to 0.
- State COMP:
  - busy=1, score_ready=1.
  - A beat is accepted when score_valid && score_ready.
  - Beat 0: max_score<=score_data, class_idx<=0, threshold latched.
  - Beat k>0: if score_data > max_score (strictly greater), then max_score<=score_data and class_idx<=k.
  - Ties keep the lower index.
  - Counter increments per accepted beat. Idle cycles (score_valid=0) stall without state change.
- COMP exit:
  - The beat with counter==NUM_CLASSES-1 is accepted -> DONE next cycle.
  - The final compare is included in the registered result.
  - rejected is registered on the same edge, computed from the updated max.
- State DONE:
  - done=1, score_ready=0.
  - class_idx, max_score and rejected are held stable.
  - start -> COMP: clears counter; done falls the next cycle; results are overwritten from beat 0.
- Throughput: one score per cycle. Minimum inference takes NUM_CLASSES cycles in COMP plus 1 cycle to DONE.
- start during COMP is ignored; the current inference completes.
- score_valid in IDLE or DONE is ignored (score_ready=0).
- Reset mid-COMP aborts immediately; no partial result is flagged.
- Arithmetic:
  - SIGNED_CMP=1: compare as $signed.
  - SIGNED_CMP=0: compare as unsigned.
  - Counter width is IDX_W; it never wraps because exit occurs at NUM_CLASSES-1.
- Illegal state encodings recover to IDLE with IDLE outputs.

Decomposition:
- Shared package elm_pkg:
  - state enum {IDLE, COMP, DONE} as 2-bit localparams
  - default ELM_CLASSES=10 and ELM_SCORE_W=16, reused by the layer engines
- One natural sub-module, argmax_cmp: a combinational compare with SIGNED_CMP/DATA_W parameters returning gt and lt_threshold. It is reused by the threshold check.
- FSM, counter and result registers stay in argmax_classifier.

Test Plan:
1. Default params, start, scores {3,7,2,9,1,0,4,9,5,6} one per cycle, threshold=5 -> done after 11 cycles from first beat, class_idx=3, max_score=9, rejected=0 (tie at index 7 ignored).
2. SIGNED_CMP=1, scores all negative {-5,-2,-8,...,-9}, threshold=0 -> class_idx=1, max_score=-2 (0xFFFE), rejected=1. Repeat with SIGNED_CMP=0 -> unsigned max selected, e.g. 0xFFFE vs 0xFFF8 ordering checked.
3. Bursty input: score_valid toggling 1,0,0,1,... -> identical result to the back-to-back case; busy stays high and done only after the 10th accepted beat.
4. Reset asserted after beat 4 of COMP -> all outputs 0 immediately (async). After release, IDLE; no done until a new start and 10 beats.
5. In DONE, pulse start with an immediate new stream {0,...,0,1} (max at index 9) -> done drops next cycle, then class_idx=9, max_score=1. start pulsed mid-COMP is ignored.
6. NUM_CLASSES=2, DATA_W=8, REJECT_EN=0 -> scores {0x80,0x7F} signed gives idx 1, rejected stays 0; min-latency path checked.
